clk_div_sched: RTL

CLK_DIV_SCHED -- requirements
Module: clk_div_sched

---
 rtl/clk_div_sched.sv | 122 ++++++++++++
 1 files changed

// File: rtl/clk_div_sched.sv
// Programmable clock divider with glitch-free ratio changes on period boundaries.
// Define CLK_DIV_ODD_EN to accept odd ratios >= 3 (high floor(N/2), low ceil(N/2)).
module clk_div_sched #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 6
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic             cfg_req,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div,
    output logic             div_clk,
    output logic             div_tick
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO = DIV_W'(2);

    state_t           state, state_n;
    logic [DIV_W-1:0] cnt, cnt_n;
    logic [DIV_W-1:0] div_n;
    logic [DIV_W-1:0] pend, pend_n;
    logic             busy_n, ack_n, err_n;
    logic             clk_n, tick_n;
    logic             legal, take, bnd;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_div  <= DIV_W'(DEF_DIV);
            pend     <= '0;
            busy     <= 1'b0;
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
            div_clk  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur_div  <= div_n;
            pend     <= pend_n;
            busy     <= busy_n;
            cfg_ack  <= ack_n;
            cfg_err  <= err_n;
            div_clk  <= clk_n;
            div_tick <= tick_n;
        end
    end

    always_comb begin
`ifdef CLK_DIV_ODD_EN
        legal = (cfg_div >= TWO);
`else
        legal = (cfg_div >= TWO) && !cfg_div[0];
`endif
    end

    assign take = cfg_req && !busy;
    assign bnd  = (state != IDLE) && (cnt == cur_div - ONE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = cur_div;
        pend_n  = pend;
        busy_n  = busy;
        ack_n   = 1'b0;
        err_n   = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (en) state_n = RUN;
            end
            RUN: begin
                cnt_n = bnd ? '0 : cnt + ONE;
                if (!en) state_n = STOP;
            end
            STOP: begin
                cnt_n = bnd ? '0 : cnt + ONE;
                if (en)       state_n = RUN;
                else if (bnd) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Ratio only moves while stopped or exactly at a period boundary
        if (take && !legal) begin
            err_n = 1'b1;
        end else if (take && (state == IDLE || bnd)) begin
            div_n = cfg_div;
            ack_n = 1'b1;
        end else if (take) begin
            pend_n = cfg_div;
            busy_n = 1'b1;
        end

        if (busy && bnd) begin
            div_n  = pend;
            busy_n = 1'b0;
            ack_n  = 1'b1;
        end

        clk_n  = (state_n != IDLE) && (cnt_n < (div_n >> 1));
        tick_n = (state_n != IDLE) && (cnt_n == '0);
    end

endmodule
